sfifo_burst_ctrl: RTL

SFIFO_BURST_CTRL -- requirements
Module: sfifo_burst_ctrl

---
 rtl/sfifo_pkg.sv | 6 +
 rtl/sfifo_burst_ctrl_if.sv | 28 ++
 rtl/sfifo_skid2.sv | 38 +++
 rtl/sfifo_burst_ctrl.sv | 82 ++++++++
 4 files changed

// File: rtl/sfifo_pkg.sv
// sfifo_pkg: burst controller state encoding and default burst length,
// shared by the controller and anything that decodes its state.
package sfifo_pkg;
    typedef enum logic [1:0] {IDLE, REQ, XFER, WAIT_LAST} state_t;
    localparam int BURST_DEF = 4;
endpackage

// File: rtl/sfifo_burst_ctrl_if.sv
// sfifo_burst_ctrl_if: FIFO-side, arbiter-side and downstream stream signals of the burst controller.
interface sfifo_burst_ctrl_if #(
    parameter int WIDTH  = 18,
    parameter int PWIDTH = 4
);
    logic              write_i;
    logic              full_i;
    logic              empty_i;
    logic              read_o;
    logic [WIDTH-1:0]  fifo_data_i;
    logic              flush_i;
    logic              req_o;
    logic              gnt_i;
    logic [WIDTH-1:0]  data_o;
    logic              valid_o;
    logic              ready_i;
    logic              last_o;
    logic [PWIDTH:0]   level_o;
    logic              busy_o;
    modport master (
        input  write_i, full_i, empty_i, fifo_data_i, flush_i, gnt_i, ready_i,
        output read_o, req_o, data_o, valid_o, last_o, level_o, busy_o
    );
    modport slave (
        output write_i, full_i, empty_i, fifo_data_i, flush_i, gnt_i, ready_i,
        input  read_o, req_o, data_o, valid_o, last_o, level_o, busy_o
    );
endinterface

// File: rtl/sfifo_skid2.sv
// sfifo_skid2: two-entry output buffer; the head always lives in entry 0
// so the downstream data comes straight from a flop.
module sfifo_skid2 #(
    parameter int WIDTH = 18
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [1:0]       count_o,
    output logic [WIDTH-1:0] head_o
);
    logic [1:0]       cnt_q, cnt_d, rem;
    logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    logic             pop;
    assign pop = pop_i && (cnt_q != 2'd0);
    // a push lands in the slot left free after this cycle's pop
    always_comb begin
        rem   = cnt_q - {1'b0, pop};
        e0_d  = (push_i && rem == 2'd0) ? data_i : pop ? e1_q : e0_q;
        e1_d  = (push_i && rem == 2'd1) ? data_i : e1_q;
        cnt_d = rem + {1'b0, push_i};
    end
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end
    assign count_o = cnt_q;
    assign head_o  = e0_q;
endmodule

// File: rtl/sfifo_burst_ctrl.sv
// sfifo_burst_ctrl: tracks FIFO occupancy, requests the downstream arbiter once a
// burst (or a flushed partial burst) is available, and streams it out with last_o.
module sfifo_burst_ctrl
    import sfifo_pkg::*;
#(
    parameter int WIDTH  = 18,
    parameter int SIZE   = 16,
    parameter int PWIDTH = 4,
    parameter int BURST  = BURST_DEF
) (
    input logic                clock_i,
    input logic                reset_i,
    sfifo_burst_ctrl_if.master bus
);
    localparam logic [PWIDTH:0] ONE     = (PWIDTH+1)'(1);
    localparam logic [PWIDTH:0] SIZE_L  = (PWIDTH+1)'(SIZE);
    localparam logic [PWIDTH:0] BURST_L = (PWIDTH+1)'(BURST);
    state_t          state_q, state_d;
    logic [PWIDTH:0] level_q, level_d, rem_q, rem_d;
    logic            infl_q, infl_d, infl_last_q, infl_last_d;
    logic            wr, rd, pop;
    logic [1:0]      buf_cnt;
    logic [2:0]      occ;
    logic [WIDTH:0]  head;
    assign wr  = bus.write_i & ~bus.full_i;
    assign pop = bus.valid_o & bus.ready_i;
    // beats already committed to the buffer after this cycle's pop; reads stop at 2
    assign occ = {1'b0, buf_cnt} + {2'b0, infl_q} - {2'b0, pop};
    assign rd  = (state_q == XFER) && (rem_q != '0) && !bus.empty_i && (occ < 3'd2);
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        infl_d      = rd;
        infl_last_d = rd && (rem_q == ONE);
        level_d     = (wr && !rd && level_q != SIZE_L) ? level_q + ONE :
                      (rd && !wr && level_q != '0)     ? level_q - ONE : level_q;
        case (state_q)
            IDLE: if (level_q >= BURST_L || (bus.flush_i && level_q != '0)) begin
                state_d = REQ;
                rem_d   = (level_q < BURST_L) ? level_q : BURST_L;
            end
            REQ: state_d = bus.gnt_i ? XFER : REQ;
            XFER: begin
                rem_d   = rd ? rem_q - ONE : rem_q;
                state_d = infl_last_d ? WAIT_LAST : XFER;
            end
            default: state_d = (pop && head[WIDTH]) ? IDLE : WAIT_LAST;
        endcase
    end
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            level_q     <= '0;
            rem_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            rem_q       <= rem_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
        end
    end
    // the last flag travels with its data word through the buffer
    sfifo_skid2 #(.WIDTH(WIDTH + 1)) u_skid (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push_i  (infl_q),
        .pop_i   (pop),
        .data_i  ({infl_last_q, bus.fifo_data_i}),
        .count_o (buf_cnt),
        .head_o  (head)
    );
    assign bus.read_o  = rd;
    assign bus.req_o   = (state_q == REQ);
    assign bus.valid_o = (buf_cnt != 2'd0);
    assign bus.data_o  = head[WIDTH-1:0];
    assign bus.last_o  = bus.valid_o & head[WIDTH];
    assign bus.level_o = level_q;
    assign bus.busy_o  = (state_q != IDLE);
endmodule
